// File: rtl/hdlc_pkg.sv
// Shared constants and state type for the HDLC receive path.
// Bit patterns are as seen on the serial line, LSB first.
package hdlc_pkg;

  localparam logic [7:0] FLAG_PAT = 8'h7E;
  localparam int ABORT_ONES = 7;
  localparam int STUFF_ONES = 5;

  typedef enum logic [1:0] {
    HUNT,
    OPEN,
    FRAME
  } rx_state_t;

endpackage

// File: rtl/hdlc_rx_flag_detect.sv
// Raw-stream front end: registers Rx, keeps an 8-bit window with drop/valid tags.
// Raises flag/abort pulses and presents the bit about to leave the window.
module hdlc_rx_flag_detect
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic RxEN,
  input  logic Rx,
  output logic FlagDetect,
  output logic AbortDetect,
  output logic BitOut,
  output logic BitKeep,
  output logic WinReady
);

  logic       rxD;
  logic [7:0] win;
  logic [7:0] drop;
  logic [7:0] vld;
  logic [2:0] ones;
  logic [7:0] nextWin;
  logic       flagNow;
  logic       abortNow;
  logic       dropNow;

  assign nextWin  = {rxD, win[7:1]};
  assign flagNow  = (nextWin == FLAG_PAT);
  assign abortNow = rxD && (ones == 3'(ABORT_ONES - 1));
  assign dropNow  = !rxD && (ones == 3'(STUFF_ONES));

  assign BitOut   = win[0];
  assign BitKeep  = vld[0] && !drop[0];
  // Seven valid bits now plus the one entering: window is all data next cycle
  assign WinReady = vld[1] && !flagNow && !abortNow;

  always_ff @(posedge Clk) begin
    if (Rst || !RxEN) begin
      rxD         <= 1'b1;
      win         <= '1;
      drop        <= '0;
      vld         <= '0;
      ones        <= '0;
      FlagDetect  <= 1'b0;
      AbortDetect <= 1'b0;
    end else begin
      rxD         <= Rx;
      win         <= nextWin;
      drop        <= {dropNow, drop[7:1]};
      vld         <= flagNow ? '0 : {1'b1, vld[7:1]};
      FlagDetect  <= flagNow;
      AbortDetect <= abortNow;
      if (!rxD)
        ones <= '0;
      else if (ones != 3'(ABORT_ONES))
        ones <= ones + 3'd1;
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: frame FSM, LSB-first byte assembly, counters, status.
// Flag/abort hunting and zero-destuffing tags live in hdlc_rx_flag_detect.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_NewByte,
  output logic [7:0] Rx_Data,
  output logic       Rx_StartFCS,
  output logic       Rx_StopFCS,
  output logic       Rx_EoF,
  output logic       Rx_AbortSignal,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic [7:0] Rx_ByteCnt
);

  rx_state_t  state;
  logic [7:0] shReg;
  logic [2:0] bitCnt;
  logic       bitOut;
  logic       bitKeep;
  logic       winReady;
  logic       inFrame;
  logic       startEv;
  logic       dataEv;
  logic [7:0] nextSh;

  hdlc_rx_flag_detect u_flag (
    .Clk         (Clk),
    .Rst         (Rst),
    .RxEN        (RxEN),
    .Rx          (Rx),
    .FlagDetect  (Rx_FlagDetect),
    .AbortDetect (Rx_AbortDetect),
    .BitOut      (bitOut),
    .BitKeep     (bitKeep),
    .WinReady    (winReady)
  );

  assign inFrame = (state == FRAME);
  assign nextSh  = {bitOut, shReg[7:1]};
  assign startEv = (state == OPEN) && winReady
                && !Rx_FlagDetect && !Rx_AbortDetect;
  assign dataEv  = inFrame && bitKeep
                && !Rx_FlagDetect && !Rx_AbortDetect;

  always_ff @(posedge Clk) begin
    if (Rst || !RxEN) begin
      state          <= HUNT;
      shReg          <= '0;
      bitCnt         <= '0;
      Rx_Data        <= '0;
      Rx_NewByte     <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_StartFCS    <= 1'b0;
      Rx_StopFCS     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_ByteCnt     <= '0;
    end else begin
      Rx_NewByte     <= 1'b0;
      Rx_StartFCS    <= 1'b0;
      Rx_StopFCS     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameError  <= 1'b0;
      unique case (1'b1)
        Rx_AbortDetect: begin
          Rx_AbortSignal <= inFrame;
          Rx_StopFCS     <= inFrame;
          Rx_ValidFrame  <= 1'b0;
          bitCnt         <= '0;
          state          <= HUNT;
        end
        Rx_FlagDetect: begin
          Rx_EoF        <= inFrame;
          Rx_StopFCS    <= inFrame;
          Rx_FrameError <= inFrame && (bitCnt != 3'd0);
          Rx_ValidFrame <= 1'b0;
          bitCnt        <= '0;
          state         <= OPEN;
        end
        startEv: begin
          Rx_StartFCS   <= 1'b1;
          Rx_ValidFrame <= 1'b1;
          Rx_ByteCnt    <= '0;
          Rx_Overflow   <= 1'b0;
          bitCnt        <= '0;
          state         <= FRAME;
        end
        dataEv: begin
          shReg  <= nextSh;
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            Rx_Data    <= nextSh;
            Rx_NewByte <= 1'b1;
            if (Rx_ByteCnt != 8'hFF)
              Rx_ByteCnt <= Rx_ByteCnt + 8'd1;
            if (int'(Rx_ByteCnt) >= MAX_FRAME_BYTES)
              Rx_Overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: bit-serial stimulus with stuffing,
// expected bytes queued at send time and compared as Rx_NewByte pulses arrive.
module tb_hdlc_rx_deframer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx = 1'b1;
  logic       RxEN = 1'b1;
  logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte;
  logic [7:0] Rx_Data;
  logic       Rx_StartFCS, Rx_StopFCS, Rx_EoF, Rx_AbortSignal;
  logic       Rx_FrameError, Rx_Overflow;
  logic [7:0] Rx_ByteCnt;

  hdlc_rx_deframer #(.MAX_FRAME_BYTES(128)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_NewByte(Rx_NewByte),
    .Rx_Data(Rx_Data), .Rx_StartFCS(Rx_StartFCS),
    .Rx_StopFCS(Rx_StopFCS), .Rx_EoF(Rx_EoF),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_FrameError(Rx_FrameError),
    .Rx_Overflow(Rx_Overflow), .Rx_ByteCnt(Rx_ByteCnt)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bitCyc, dataCyc, txOnes;
  logic [7:0] expQ[$];
  int nbCyc[$];
  int nb, flg, abd, eof, ferr, sfc, pfc, asig;
  int flagCyc, abdCyc, asigCyc, eofCyc, ferrCyc, ovfCyc;
  int fBit, b0, aBit;
  logic prevOvf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    nb = 0; flg = 0; abd = 0; eof = 0;
    ferr = 0; sfc = 0; pfc = 0; asig = 0;
    flagCyc = -1; abdCyc = -1; asigCyc = -1;
    eofCyc = -1; ferrCyc = -1; ovfCyc = -1;
    nbCyc.delete();
  endtask

  // Bit b is on Rx during cycle bitCyc; sampled outputs belong to bitCyc+1.
  task automatic step(input logic b);
    Rx = b;
    bitCyc = cyc;
    @(posedge Clk);
    #1;
    cyc++;
    if (Rx_NewByte) begin
      nb++;
      nbCyc.push_back(cyc);
      check("byte_pending", 32'(expQ.size() > 0), 1);
      if (expQ.size() > 0)
        check("rx_data", 32'(Rx_Data), 32'(expQ.pop_front()));
    end
    if (Rx_Overflow && !prevOvf) ovfCyc = cyc;
    prevOvf = Rx_Overflow;
    if (Rx_FlagDetect) begin flg++; flagCyc = cyc; end
    if (Rx_AbortDetect) begin abd++; abdCyc = cyc; end
    if (Rx_FrameError) begin ferr++; ferrCyc = cyc; end
    if (Rx_StopFCS) pfc++;
    if (Rx_EoF) begin
      eof++; eofCyc = cyc;
      check("valid_low_at_eof", 32'(Rx_ValidFrame), 0);
    end
    if (Rx_AbortSignal) begin
      asig++; asigCyc = cyc;
      check("valid_low_at_abort", 32'(Rx_ValidFrame), 0);
    end
    if (Rx_StartFCS) begin
      sfc++;
      check("ovf_clear_at_start", 32'(Rx_Overflow), 0);
      check("cnt_clear_at_start", 32'(Rx_ByteCnt), 0);
    end
  endtask

  task automatic sendBits(input logic [7:0] v, input int n,
                          input bit stuff);
    for (int i = 0; i < n; i++) begin
      step(v[i]);
      dataCyc = bitCyc;
      if (stuff) begin
        txOnes = v[i] ? txOnes + 1 : 0;
        if (txOnes == 5) begin
          step(1'b0);
          txOnes = 0;
        end
      end
    end
  endtask

  task automatic sendByte(input logic [7:0] v);
    expQ.push_back(v);
    sendBits(v, 8, 1'b1);
  endtask

  task automatic sendFlag();
    sendBits(8'h7E, 8, 1'b0);
    txOnes = 0;
  endtask

  initial begin
    txOnes = 0;
    clr();
    step(1'b1);
    step(1'b1);
    Rst = 1'b0;
    check("rst_data", 32'(Rx_Data), 0);
    check("rst_valid", 32'(Rx_ValidFrame), 0);
    check("rst_ovf", 32'(Rx_Overflow), 0);
    check("rst_cnt", 32'(Rx_ByteCnt), 0);
    check("rst_newbyte", 32'(Rx_NewByte), 0);
    check("rst_flag", 32'(Rx_FlagDetect), 0);

    // idle line: a single abort, nothing else
    clr();
    repeat (30) step(1'b1);
    check("idle_aborts", abd, 1);
    check("idle_flags", flg, 0);
    check("idle_bytes", nb, 0);

    // open flag, 0x55, stuffed 0xFF, closing flag
    clr();
    sendFlag();
    fBit = bitCyc;
    sendByte(8'h55);
    b0 = dataCyc;
    check("flag_count", flg, 1);
    check("flag_latency", flagCyc - fBit, 2);
    sendByte(8'hFF);
    sendFlag();
    sendFlag();
    check("f1_bytes", nb, 2);
    check("f1_latency", (nbCyc.size() > 0) ? nbCyc[0] - b0 : -1, 10);
    check("f1_bytecnt", 32'(Rx_ByteCnt), 2);
    check("f1_eof", eof, 1);
    check("f1_ferr", ferr, 0);
    check("f1_start", sfc, 1);
    check("f1_stop", pfc, 1);

    // 0xA3 plus 3 stray bits: non-aligned close
    clr();
    sendByte(8'hA3);
    sendBits(8'h05, 3, 1'b1);
    sendFlag();
    sendFlag();
    check("f2_bytes", nb, 1);
    check("f2_eof", eof, 1);
    check("f2_ferr", ferr, 1);
    check("f2_ferr_with_eof", ferrCyc, eofCyc);

    // two bytes then abort (0 + seven 1s)
    clr();
    sendByte(8'h12);
    sendByte(8'h34);
    sendBits(8'hFE, 8, 1'b0);
    aBit = bitCyc;
    repeat (12) step(1'b1);
    check("ab_detect", abd, 1);
    check("ab_latency", abdCyc - aBit, 2);
    check("ab_signal", asig, 1);
    check("ab_signal_lag", asigCyc - abdCyc, 1);
    check("ab_no_eof", eof, 0);
    check("ab_bytes", nb, 2);
    check("ab_stop", pfc, 1);
    check("ab_valid", 32'(Rx_ValidFrame), 0);

    // 129 zero bytes: overflow on the last one
    clr();
    sendFlag();
    repeat (129) sendByte(8'h00);
    sendFlag();
    sendFlag();
    check("ov_bytes", nb, 129);
    check("ov_rise", ovfCyc, (nbCyc.size() > 128) ? nbCyc[128] : -2);
    check("ov_bytecnt", 32'(Rx_ByteCnt), 129);
    check("ov_held", 32'(Rx_Overflow), 1);
    check("ov_eof", eof, 1);

    // next frame start clears overflow
    clr();
    sendByte(8'h5A);
    sendFlag();
    sendFlag();
    check("nx_start", sfc, 1);
    check("nx_bytes", nb, 1);
    check("nx_ovf", 32'(Rx_Overflow), 0);
    check("nx_bytecnt", 32'(Rx_ByteCnt), 1);

    // RxEN low with second byte half assembled
    clr();
    sendByte(8'h11);
    sendBits(8'h22, 8, 1'b1);
    sendBits(8'h33, 4, 1'b1);
    check("en_pre_valid", 32'(Rx_ValidFrame), 1);
    check("en_pre_data", 32'(Rx_Data), 8'h11);
    RxEN = 1'b0;
    step(1'b1);
    check("en_valid", 32'(Rx_ValidFrame), 0);
    check("en_data", 32'(Rx_Data), 0);
    check("en_cnt", 32'(Rx_ByteCnt), 0);
    check("en_newbyte", 32'(Rx_NewByte), 0);
    repeat (5) step(1'b1);
    check("en_quiet_abort", abd, 0);
    RxEN = 1'b1;
    repeat (20) step(1'b1);
    check("en_bytes", nb, 1);
    check("en_eof", eof, 0);

    // Rst mid-frame
    clr();
    sendFlag();
    sendByte(8'h66);
    sendBits(8'h77, 8, 1'b1);
    sendBits(8'h01, 4, 1'b1);
    check("rs_pre_valid", 32'(Rx_ValidFrame), 1);
    check("rs_pre_data", 32'(Rx_Data), 8'h66);
    Rst = 1'b1;
    step(1'b1);
    check("rs_valid", 32'(Rx_ValidFrame), 0);
    check("rs_data", 32'(Rx_Data), 0);
    check("rs_cnt", 32'(Rx_ByteCnt), 0);
    Rst = 1'b0;
    repeat (20) step(1'b1);
    check("rs_bytes", nb, 1);
    check("queue_empty", 32'(expQ.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
